// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: DEPTH-stage control-word pipeline from ID to WB with per-stage
// stall and bubble insertion, flush of younger stages, retire counting and a sticky halt.
module ctrl_pipe_chain #(
  parameter int DEPTH    = 3,
  parameter int W        = 16,
  parameter int CNT_W    = 16,
  parameter int HALT_BIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [W-1:0]       in_word,
  output logic               in_ready,
  input  logic [DEPTH-1:0]   stall,
  input  logic [DEPTH-1:0]   flush,
  output logic [DEPTH-1:0]   stage_valid,
  output logic [DEPTH*W-1:0] stage_word,
  output logic               out_valid,
  output logic [W-1:0]       out_word,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               halted
);

  logic [DEPTH-1:0]        valid_r;
  logic [DEPTH-1:0][W-1:0] word_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    halted_r;

  logic [DEPTH-1:0]        hold_s;
  logic [DEPTH-1:0]        kill_s;
  logic [DEPTH-1:0]        valid_nxt_s;
  logic [DEPTH-1:0][W-1:0] word_nxt_s;
  logic                    retire_s;
  logic                    halt_retire_s;

  // Suffix-OR of stall/flush: an older stage's stall or flush reaches every younger stage.
  always_comb begin
    hold_s          = {DEPTH{1'b0}};
    kill_s          = {DEPTH{1'b0}};
    hold_s[DEPTH-1] = halted_r | stall[DEPTH-1];
    kill_s[DEPTH-1] = flush[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold_s[i] = hold_s[i+1] | stall[i];
      kill_s[i] = kill_s[i+1] | flush[i];
    end
  end

  // Next state per stage: kill beats hold; a stage whose predecessor holds takes a bubble.
  always_comb begin
    valid_nxt_s = valid_r;
    word_nxt_s  = word_r;

    if (kill_s[0]) begin
      valid_nxt_s[0] = 1'b0;
      word_nxt_s[0]  = {W{1'b0}};
    end else if (hold_s[0]) begin
      valid_nxt_s[0] = valid_r[0];
      word_nxt_s[0]  = word_r[0];
    end else begin
      valid_nxt_s[0] = in_valid;
      word_nxt_s[0]  = in_valid ? in_word : {W{1'b0}};
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (kill_s[i]) begin
        valid_nxt_s[i] = 1'b0;
        word_nxt_s[i]  = {W{1'b0}};
      end else if (hold_s[i]) begin
        valid_nxt_s[i] = valid_r[i];
        word_nxt_s[i]  = word_r[i];
      end else if (hold_s[i-1]) begin
        valid_nxt_s[i] = 1'b0;
        word_nxt_s[i]  = {W{1'b0}};
      end else begin
        valid_nxt_s[i] = valid_r[i-1];
        word_nxt_s[i]  = word_r[i-1];
      end
    end
  end

  // A flush of the last stage still lets the word it presents retire this edge.
  assign retire_s      = valid_r[DEPTH-1] & ~hold_s[DEPTH-1];
  assign halt_retire_s = retire_s & word_r[DEPTH-1][HALT_BIT];

  // Stage registers, retire counter and sticky halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= {DEPTH{1'b0}};
      word_r   <= {(DEPTH*W){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      halted_r <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      word_r  <= word_nxt_s;
      if (retire_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      if (halt_retire_s) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= halted_r;
      end
    end
  end

  assign in_ready    = ~hold_s[0];
  assign stage_valid = valid_r;
  assign stage_word  = word_r;
  assign out_valid   = valid_r[DEPTH-1];
  assign out_word    = word_r[DEPTH-1];
  assign retire_cnt  = cnt_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (DEPTH=3, W=8, CNT_W=4, HALT_BIT=7): vector table
// plus hand sequences for counter wrap, last-stage stall and last-stage flush.
module tb_ctrl_pipe_chain;
  localparam int DEPTH    = 3;
  localparam int W        = 8;
  localparam int CNT_W    = 4;
  localparam int HALT_BIT = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [W-1:0]       in_word;
  logic               in_ready;
  logic [DEPTH-1:0]   stall;
  logic [DEPTH-1:0]   flush;
  logic [DEPTH-1:0]   stage_valid;
  logic [DEPTH*W-1:0] stage_word;
  logic               out_valid;
  logic [W-1:0]       out_word;
  logic [CNT_W-1:0]   retire_cnt;
  logic               halted;

  always #5 clk = ~clk;

  ctrl_pipe_chain #(.DEPTH(DEPTH), .W(W), .CNT_W(CNT_W), .HALT_BIT(HALT_BIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .stage_word(stage_word),
    .out_valid(out_valid), .out_word(out_word), .retire_cnt(retire_cnt), .halted(halted)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  iw;
    logic [2:0]  st;
    logic [2:0]  fl;
    logic        chk_rdy;
    logic        rdy;
    logic [2:0]  sv;
    logic [23:0] sw;
    logic [3:0]  cnt;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] iw,
                              input logic [2:0] st, input logic [2:0] fl, input logic chk,
                              input logic rdy, input logic [2:0] sv, input logic [23:0] sw,
                              input logic [3:0] cnt, input logic hlt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.iw = iw; v.st = st; v.fl = fl; v.chk_rdy = chk;
    v.rdy = rdy; v.sv = sv; v.sw = sw; v.cnt = cnt; v.hlt = hlt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic iv, input logic [7:0] iw,
                       input logic [2:0] st, input logic [2:0] fl);
    @(negedge clk);
    reset = rst; in_valid = iv; in_word = iw; stall = st; flush = fl;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic iv, input logic [7:0] iw,
                     input logic [2:0] st, input logic [2:0] fl);
    apply(rst, iv, iw, st, fl);
    edge_wait();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_word = 8'h00; stall = 3'b000; flush = 3'b000;

    // reset with in_valid high, then stream 01,02,03
    vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 24'h000000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h01, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001, 24'h000001, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h02, 3'b000, 3'b000, 1'b1, 1'b1, 3'b011, 24'h000102, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h03, 3'b000, 3'b000, 1'b1, 1'b1, 3'b111, 24'h010203, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 3'b110, 24'h020300, 4'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 3'b100, 24'h030000, 4'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd3, 1'b0));
    // fill C,B,A then stall stage 1: bubble into stage 2, C retires once
    vecs.push_back(mk(1'b0, 1'b1, 8'h0C, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001, 24'h00000C, 4'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h0B, 3'b000, 3'b000, 1'b1, 1'b1, 3'b011, 24'h000C0B, 4'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h0A, 3'b000, 3'b000, 1'b1, 1'b1, 3'b111, 24'h0C0B0A, 4'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h0D, 3'b010, 3'b000, 1'b1, 1'b0, 3'b011, 24'h000B0A, 4'd4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h0D, 3'b000, 3'b000, 1'b1, 1'b1, 3'b111, 24'h0B0A0D, 4'd4, 1'b0));
    // flush stage 1 with stall stage 0: kill wins, stage 2 still advances
    vecs.push_back(mk(1'b0, 1'b1, 8'h0E, 3'b001, 3'b010, 1'b1, 1'b0, 3'b100, 24'h0A0000, 4'd5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd6, 1'b0));
    // halt word 0x81 retires; everything frozen afterwards, flush still clears
    vecs.push_back(mk(1'b0, 1'b1, 8'h81, 3'b000, 3'b000, 1'b1, 1'b1, 3'b001, 24'h000081, 4'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h05, 3'b000, 3'b000, 1'b1, 1'b1, 3'b011, 24'h008105, 4'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h06, 3'b000, 3'b000, 1'b1, 1'b1, 3'b111, 24'h810506, 4'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h07, 3'b000, 3'b000, 1'b1, 1'b1, 3'b111, 24'h050607, 4'd7, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h08, 3'b000, 3'b000, 1'b1, 1'b0, 3'b111, 24'h050607, 4'd7, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h08, 3'b000, 3'b100, 1'b1, 1'b0, 3'b000, 24'h000000, 4'd7, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h09, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 24'h000000, 4'd7, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h09, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 24'h000000, 4'd0, 1'b0));
    // invalid input carrying bit7=1 must never set halted
    vecs.push_back(mk(1'b0, 1'b0, 8'h80, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h80, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h80, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd0, 1'b0));

    foreach (vecs[k]) begin
      apply(vecs[k].rst, vecs[k].iv, vecs[k].iw, vecs[k].st, vecs[k].fl);
      if (vecs[k].chk_rdy) check($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, {31'd0, vecs[k].rdy});
      edge_wait();
      check($sformatf("v%0d_stage_valid", k), {29'd0, stage_valid}, {29'd0, vecs[k].sv});
      check($sformatf("v%0d_stage_word", k), {8'd0, stage_word}, {8'd0, vecs[k].sw});
      check($sformatf("v%0d_out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].sv[2]});
      check($sformatf("v%0d_out_word", k), {24'd0, out_word}, {24'd0, vecs[k].sw[23:16]});
      check($sformatf("v%0d_retire_cnt", k), {28'd0, retire_cnt}, {28'd0, vecs[k].cnt});
      check($sformatf("v%0d_halted", k), {31'd0, halted}, {31'd0, vecs[k].hlt});
    end

    // 17 retirements wrap a 4-bit counter to 1
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 8'h10 + 8'(i), 3'b000, 3'b000);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    end
    check("wrap_retire_cnt", {28'd0, retire_cnt}, 32'd1);
    check("wrap_halted", {31'd0, halted}, 32'd0);

    // stall of the last stage blocks the retire and backpressures the input
    cyc(1'b0, 1'b1, 8'h33, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    check("st2_out_word_pre", {24'd0, out_word}, 32'h33);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 8'h55, 3'b100, 3'b000);
      check("st2_in_ready", {31'd0, in_ready}, 32'd0);
      edge_wait();
      check("st2_retire_cnt_held", {28'd0, retire_cnt}, 32'd1);
      check("st2_out_word_held", {24'd0, out_word}, 32'h33);
      check("st2_stage0_valid", {31'd0, stage_valid[0]}, 32'd0);
    end
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    check("st2_retire_cnt_release", {28'd0, retire_cnt}, 32'd2);
    check("st2_out_valid_release", {31'd0, out_valid}, 32'd0);

    // flush of the last stage still retires the word it presents
    cyc(1'b0, 1'b1, 8'h44, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
    check("fl2_out_word_pre", {24'd0, out_word}, 32'h44);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b100);
    check("fl2_retire_cnt", {28'd0, retire_cnt}, 32'd3);
    check("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl2_out_word", {24'd0, out_word}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
